// File: rtl/cv_bank_mapper.sv
// Cartridge bank mapper and memory-configuration registers for the Colecovision/ADAM core.
// Flat, MegaCart and I/O-register mappers; every register write fires once per bus access.
module cv_bank_mapper #(
    parameter int          PAGE_W    = 6,
    parameter logic [7:0]  CFG_PORT  = 8'h7F,
    parameter logic [7:0]  EOS_PORT  = 8'h3F,
    parameter logic [7:0]  BANK_PORT = 8'h60
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              adam_i,
    input  logic [1:0]        mapper_mode_i,
    input  logic [PAGE_W-1:0] cart_mask_i,
    input  logic [15:0]       a_i,
    input  logic [7:0]        d_i,
    input  logic              mreq_n_i,
    input  logic              iorq_n_i,
    input  logic              rd_n_i,
    input  logic              wr_n_i,
    input  logic              rfsh_n_i,
    output logic [PAGE_W-1:0] cart_page_o,
    output logic [1:0]        lower_mem_o,
    output logic [1:0]        upper_mem_o,
    output logic              eos_en_o,
    output logic              bank_switch_o
);

    localparam logic [1:0] MODE_MEGA    = 2'b01;
    localparam logic [1:0] MODE_IOREG   = 2'b10;
    localparam logic [7:0] BANK_PORT_HI = BANK_PORT + 8'd1;

    logic [PAGE_W-1:0] r_page0;
    logic [PAGE_W-1:0] r_page1;
    logic [1:0]        r_lower;
    logic [1:0]        r_upper;
    logic              r_eos;
    logic              r_bank_sw;
    logic              r_mem_q;
    logic              r_io_q;
    logic [1:0]        r_mode_q;

    logic              w_mem_acc;
    logic              w_io_wr;
    logic              w_mem_edge;
    logic              w_io_edge;
    logic              w_mode_chg;
    logic              w_page_chg;
    logic [PAGE_W-1:0] w_page1_rst;
    logic [PAGE_W-1:0] w_page0_nxt;
    logic [PAGE_W-1:0] w_page1_nxt;
    logic [PAGE_W-1:0] w_cart_page;

    // Simultaneous mreq and iorq is not a valid Z80 cycle, so it qualifies neither access.
    assign w_mem_acc   = ~mreq_n_i & rfsh_n_i & iorq_n_i & (~rd_n_i | ~wr_n_i);
    assign w_io_wr     = ~iorq_n_i & mreq_n_i & ~wr_n_i;
    assign w_mem_edge  = w_mem_acc & ~r_mem_q;
    assign w_io_edge   = w_io_wr & ~r_io_q;
    assign w_mode_chg  = (mapper_mode_i != r_mode_q);
    assign w_page1_rst = PAGE_W'(1) & cart_mask_i;

    always_comb begin
        w_page0_nxt = r_page0;
        w_page1_nxt = r_page1;
        if (w_mode_chg) begin
            w_page0_nxt = '0;
            w_page1_nxt = w_page1_rst;
        end else begin
            case (mapper_mode_i)
                MODE_MEGA: begin
                    // MegaCart switches on reads of the top 64 bytes only; writes there are ignored.
                    if (w_mem_edge && !rd_n_i && a_i[15:6] == 10'h3FF)
                        w_page1_nxt = PAGE_W'(a_i[5:0]) & cart_mask_i;
                end
                MODE_IOREG: begin
                    if (w_io_edge && a_i[7:0] == BANK_PORT)
                        w_page0_nxt = PAGE_W'(d_i) & cart_mask_i;
                    else if (w_io_edge && a_i[7:0] == BANK_PORT_HI)
                        w_page1_nxt = PAGE_W'(d_i) & cart_mask_i;
                end
                default: ;
            endcase
        end
    end

    assign w_page_chg = (w_page0_nxt != r_page0) || (w_page1_nxt != r_page1);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_page0   <= '0;
            r_page1   <= w_page1_rst;
            r_lower   <= adam_i ? 2'b00 : 2'b11;
            r_upper   <= adam_i ? 2'b00 : 2'b11;
            r_eos     <= 1'b0;
            r_bank_sw <= 1'b0;
            r_mem_q   <= 1'b0;
            r_io_q    <= 1'b0;
            // Track the live mode so leaving reset is not mistaken for a mode change.
            r_mode_q  <= mapper_mode_i;
        end else begin
            r_mem_q   <= w_mem_acc;
            r_io_q    <= w_io_wr;
            r_mode_q  <= mapper_mode_i;
            r_page0   <= w_page0_nxt;
            r_page1   <= w_page1_nxt;
            r_bank_sw <= w_mode_chg | w_page_chg;
            if (w_io_edge && a_i[7:0] == CFG_PORT) begin
                r_lower <= d_i[1:0];
                r_upper <= d_i[3:2];
            end
            if (w_io_edge && a_i[7:0] == EOS_PORT)
                r_eos <= d_i[1];
        end
    end

    always_comb begin
        w_cart_page = '0;
        if (a_i[15:14] == 2'b10) begin
            if (mapper_mode_i == MODE_MEGA)
                w_cart_page = cart_mask_i;
            else if (mapper_mode_i == MODE_IOREG)
                w_cart_page = r_page0;
        end else if (a_i[15:14] == 2'b11) begin
            if (mapper_mode_i == MODE_MEGA || mapper_mode_i == MODE_IOREG)
                w_cart_page = r_page1;
            else
                w_cart_page = w_page1_rst;
        end
    end

    assign cart_page_o   = w_cart_page;
    assign lower_mem_o   = r_lower;
    assign upper_mem_o   = r_upper;
    assign eos_en_o      = r_eos;
    assign bank_switch_o = r_bank_sw;

endmodule

// File: tb/tb_cv_bank_mapper.sv
// Bench for cv_bank_mapper: directed vector table, reset corner sequences and
// randomized traffic checked against a rule-level model.
module tb_cv_bank_mapper;

    localparam int PW = 6;

    localparam logic [4:0] IDLE = 5'b11111;  // {mreq_n, iorq_n, rd_n, wr_n, rfsh_n}
    localparam logic [4:0] MRD  = 5'b01011;
    localparam logic [4:0] MWR  = 5'b01101;
    localparam logic [4:0] IOWR = 5'b10101;
    localparam logic [4:0] IORD = 5'b10011;
    localparam logic [4:0] BOTH = 5'b00101;
    localparam logic [4:0] RFSH = 5'b01010;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          adam_i;
    logic [1:0]    mapper_mode_i;
    logic [PW-1:0] cart_mask_i;
    logic [15:0]   a_i;
    logic [7:0]    d_i;
    logic [4:0]    strb;
    logic          mreq_n_i, iorq_n_i, rd_n_i, wr_n_i, rfsh_n_i;
    logic [PW-1:0] cart_page_o;
    logic [1:0]    lower_mem_o, upper_mem_o;
    logic          eos_en_o, bank_switch_o;

    assign {mreq_n_i, iorq_n_i, rd_n_i, wr_n_i, rfsh_n_i} = strb;

    always #5 clk_i = ~clk_i;

    cv_bank_mapper #(.PAGE_W(PW)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .adam_i(adam_i),
        .mapper_mode_i(mapper_mode_i), .cart_mask_i(cart_mask_i),
        .a_i(a_i), .d_i(d_i),
        .mreq_n_i(mreq_n_i), .iorq_n_i(iorq_n_i), .rd_n_i(rd_n_i),
        .wr_n_i(wr_n_i), .rfsh_n_i(rfsh_n_i),
        .cart_page_o(cart_page_o), .lower_mem_o(lower_mem_o),
        .upper_mem_o(upper_mem_o), .eos_en_o(eos_en_o),
        .bank_switch_o(bank_switch_o)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [PW-1:0] m_p0, m_p1;
    logic [1:0]    m_lo, m_up, m_mode;
    logic          m_eos, m_bsw, m_pm, m_pi;

    typedef struct {
        logic [1:0]    mode;
        logic [PW-1:0] mask;
        logic [15:0]   a;
        logic [7:0]    d;
        logic [4:0]    st;
        logic [PW-1:0] pg;
        logic [1:0]    lo;
        logic [1:0]    up;
        logic          eos;
        logic          bsw;
    } vec_t;

    vec_t tbl[34];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_p0   = '0;
        m_p1   = PW'(1) & cart_mask_i;
        m_lo   = adam_i ? 2'b00 : 2'b11;
        m_up   = adam_i ? 2'b00 : 2'b11;
        m_eos  = 1'b0;
        m_bsw  = 1'b0;
        m_pm   = 1'b0;
        m_pi   = 1'b0;
        m_mode = mapper_mode_i;
    endtask

    task automatic model_step();
        logic mem, io;
        logic [PW-1:0] o0, o1;
        if (!reset_n_i) begin
            model_reset();
            return;
        end
        mem = !mreq_n_i && rfsh_n_i && iorq_n_i && (!rd_n_i || !wr_n_i);
        io  = !iorq_n_i && mreq_n_i && !wr_n_i;
        o0 = m_p0;
        o1 = m_p1;
        if (mapper_mode_i != m_mode) begin
            m_p0  = '0;
            m_p1  = PW'(1) & cart_mask_i;
            m_bsw = 1'b1;
        end else begin
            if (mapper_mode_i == 2'd1 && mem && !m_pm && !rd_n_i && a_i >= 16'hFFC0)
                m_p1 = a_i[5:0] & cart_mask_i;
            if (mapper_mode_i == 2'd2 && io && !m_pi && a_i[7:0] == 8'h60)
                m_p0 = d_i[5:0] & cart_mask_i;
            if (mapper_mode_i == 2'd2 && io && !m_pi && a_i[7:0] == 8'h61)
                m_p1 = d_i[5:0] & cart_mask_i;
            m_bsw = (m_p0 != o0) || (m_p1 != o1);
        end
        if (io && !m_pi && a_i[7:0] == 8'h7F) begin
            m_lo = d_i[1:0];
            m_up = d_i[3:2];
        end
        if (io && !m_pi && a_i[7:0] == 8'h3F)
            m_eos = d_i[1];
        m_pm   = mem;
        m_pi   = io;
        m_mode = mapper_mode_i;
    endtask

    function automatic logic [PW-1:0] exp_page();
        if (a_i[15:14] == 2'b10)
            return (mapper_mode_i == 2'd1) ? cart_mask_i :
                   (mapper_mode_i == 2'd2) ? m_p0 : '0;
        if (a_i[15:14] == 2'b11)
            return (mapper_mode_i == 2'd1 || mapper_mode_i == 2'd2) ? m_p1
                                                                     : (PW'(1) & cart_mask_i);
        return '0;
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".page"}, 32'(cart_page_o), 32'(exp_page()));
        chk({tag, ".lower"}, 32'(lower_mem_o), 32'(m_lo));
        chk({tag, ".upper"}, 32'(upper_mem_o), 32'(m_up));
        chk({tag, ".eos"}, 32'(eos_en_o), 32'(m_eos));
        chk({tag, ".bsw"}, 32'(bank_switch_o), 32'(m_bsw));
    endtask

    task automatic cycle();
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
    endtask

    task automatic drive(input logic [1:0] md, input logic [PW-1:0] mk,
                         input logic [15:0] a, input logic [7:0] d, input logic [4:0] st);
        mapper_mode_i = md;
        cart_mask_i   = mk;
        a_i           = a;
        d_i           = d;
        strb          = st;
    endtask

    initial begin
        //          mode  mask   a         d      strobe  page   lo    up    eos   bsw
        tbl[0]  = '{2'd1, 6'h1F, 16'hC000, 8'h00, IDLE, 6'h01, 2'd3, 2'd3, 1'b0, 1'b0};
        tbl[1]  = '{2'd1, 6'h1F, 16'hFFC5, 8'h00, MRD,  6'h05, 2'd3, 2'd3, 1'b0, 1'b1};
        tbl[2]  = '{2'd1, 6'h1F, 16'hFFC5, 8'h00, MRD,  6'h05, 2'd3, 2'd3, 1'b0, 1'b0};
        tbl[3]  = '{2'd1, 6'h1F, 16'hFFC5, 8'h00, MRD,  6'h05, 2'd3, 2'd3, 1'b0, 1'b0};
        tbl[4]  = '{2'd1, 6'h1F, 16'hC000, 8'h00, IDLE, 6'h05, 2'd3, 2'd3, 1'b0, 1'b0};
        tbl[5]  = '{2'd1, 6'h1F, 16'h8000, 8'h00, IDLE, 6'h1F, 2'd3, 2'd3, 1'b0, 1'b0};
        tbl[6]  = '{2'd1, 6'h1F, 16'hFFC7, 8'hAA, MWR,  6'h05, 2'd3, 2'd3, 1'b0, 1'b0};
        tbl[7]  = '{2'd1, 6'h1F, 16'hC000, 8'h00, IDLE, 6'h05, 2'd3, 2'd3, 1'b0, 1'b0};
        tbl[8]  = '{2'd1, 6'h1F, 16'hFFC5, 8'h00, MRD,  6'h05, 2'd3, 2'd3, 1'b0, 1'b0};
        tbl[9]  = '{2'd1, 6'h1F, 16'hC000, 8'h00, IDLE, 6'h05, 2'd3, 2'd3, 1'b0, 1'b0};
        tbl[10] = '{2'd2, 6'h0F, 16'hC000, 8'h00, IDLE, 6'h01, 2'd3, 2'd3, 1'b0, 1'b1};
        tbl[11] = '{2'd2, 6'h0F, 16'h0060, 8'h17, IOWR, 6'h00, 2'd3, 2'd3, 1'b0, 1'b1};
        tbl[12] = '{2'd2, 6'h0F, 16'h8000, 8'h00, IDLE, 6'h07, 2'd3, 2'd3, 1'b0, 1'b0};
        tbl[13] = '{2'd2, 6'h0F, 16'h0061, 8'h03, IOWR, 6'h00, 2'd3, 2'd3, 1'b0, 1'b1};
        tbl[14] = '{2'd2, 6'h0F, 16'hC000, 8'h00, IDLE, 6'h03, 2'd3, 2'd3, 1'b0, 1'b0};
        tbl[15] = '{2'd2, 6'h0F, 16'h8000, 8'h00, IDLE, 6'h07, 2'd3, 2'd3, 1'b0, 1'b0};
        tbl[16] = '{2'd2, 6'h0F, 16'h007F, 8'h06, IOWR, 6'h00, 2'd2, 2'd1, 1'b0, 1'b0};
        tbl[17] = '{2'd2, 6'h0F, 16'h0000, 8'h00, IDLE, 6'h00, 2'd2, 2'd1, 1'b0, 1'b0};
        tbl[18] = '{2'd2, 6'h0F, 16'h007F, 8'h0F, IOWR, 6'h00, 2'd3, 2'd3, 1'b0, 1'b0};
        tbl[19] = '{2'd2, 6'h0F, 16'h0000, 8'h00, IDLE, 6'h00, 2'd3, 2'd3, 1'b0, 1'b0};
        tbl[20] = '{2'd2, 6'h0F, 16'h003F, 8'h02, IOWR, 6'h00, 2'd3, 2'd3, 1'b1, 1'b0};
        tbl[21] = '{2'd2, 6'h0F, 16'h0000, 8'h00, IDLE, 6'h00, 2'd3, 2'd3, 1'b1, 1'b0};
        tbl[22] = '{2'd2, 6'h0F, 16'h007F, 8'h00, BOTH, 6'h00, 2'd3, 2'd3, 1'b1, 1'b0};
        tbl[23] = '{2'd2, 6'h0F, 16'h003F, 8'h00, BOTH, 6'h00, 2'd3, 2'd3, 1'b1, 1'b0};
        tbl[24] = '{2'd2, 6'h0F, 16'h0060, 8'h0C, BOTH, 6'h00, 2'd3, 2'd3, 1'b1, 1'b0};
        tbl[25] = '{2'd2, 6'h0F, 16'h8000, 8'h00, IDLE, 6'h07, 2'd3, 2'd3, 1'b1, 1'b0};
        tbl[26] = '{2'd0, 6'h0F, 16'hC000, 8'h00, IDLE, 6'h01, 2'd3, 2'd3, 1'b1, 1'b1};
        tbl[27] = '{2'd0, 6'h0F, 16'h8000, 8'h00, IDLE, 6'h00, 2'd3, 2'd3, 1'b1, 1'b0};
        tbl[28] = '{2'd0, 6'h0F, 16'h0060, 8'h05, IOWR, 6'h00, 2'd3, 2'd3, 1'b1, 1'b0};
        tbl[29] = '{2'd0, 6'h0F, 16'hC000, 8'h00, IDLE, 6'h01, 2'd3, 2'd3, 1'b1, 1'b0};
        tbl[30] = '{2'd0, 6'h00, 16'hC000, 8'h00, IDLE, 6'h00, 2'd3, 2'd3, 1'b1, 1'b0};
        tbl[31] = '{2'd1, 6'h00, 16'h8000, 8'h00, IDLE, 6'h00, 2'd3, 2'd3, 1'b1, 1'b1};
        tbl[32] = '{2'd1, 6'h00, 16'hFFC9, 8'h00, MRD,  6'h00, 2'd3, 2'd3, 1'b1, 1'b0};
        tbl[33] = '{2'd1, 6'h1F, 16'hC000, 8'h00, IDLE, 6'h00, 2'd3, 2'd3, 1'b1, 1'b0};

        // reset defaults for ADAM then Colecovision
        reset_n_i = 1'b0;
        adam_i    = 1'b1;
        drive(2'd1, 6'h1F, 16'hC000, 8'h00, IDLE);
        model_reset();
        cycle();
        chk("rst_adam.lower", 32'(lower_mem_o), 32'd0);
        chk("rst_adam.upper", 32'(upper_mem_o), 32'd0);
        chk("rst_adam.page1", 32'(cart_page_o), 32'd1);
        chk("rst_adam.eos", 32'(eos_en_o), 32'd0);
        chk("rst_adam.bsw", 32'(bank_switch_o), 32'd0);
        adam_i = 1'b0;
        cycle();
        chk("rst_cv.lower", 32'(lower_mem_o), 32'd3);
        chk("rst_cv.upper", 32'(upper_mem_o), 32'd3);
        check_model("rst_cv");
        reset_n_i = 1'b1;
        drive(2'd1, 6'h1F, 16'h0000, 8'h00, IDLE);
        cycle();
        check_model("post_rst");

        for (int i = 0; i < 34; i++) begin
            drive(tbl[i].mode, tbl[i].mask, tbl[i].a, tbl[i].d, tbl[i].st);
            cycle();
            chk($sformatf("vec%0d.page", i), 32'(cart_page_o), 32'(tbl[i].pg));
            chk($sformatf("vec%0d.lower", i), 32'(lower_mem_o), 32'(tbl[i].lo));
            chk($sformatf("vec%0d.upper", i), 32'(upper_mem_o), 32'(tbl[i].up));
            chk($sformatf("vec%0d.eos", i), 32'(eos_en_o), 32'(tbl[i].eos));
            chk($sformatf("vec%0d.bsw", i), 32'(bank_switch_o), 32'(tbl[i].bsw));
            check_model($sformatf("vec%0d.model", i));
        end

        // reset asserted in the middle of a held FFC3 read, then released
        drive(2'd1, 6'h1F, 16'hFFC3, 8'h00, MRD);
        cycle();
        chk("midrst.pre_page", 32'(cart_page_o), 32'd3);
        chk("midrst.pre_bsw", 32'(bank_switch_o), 32'd1);
        reset_n_i = 1'b0;
        model_reset();
        #1;
        chk("midrst.async_page", 32'(cart_page_o), 32'd1);
        chk("midrst.async_bsw", 32'(bank_switch_o), 32'd0);
        chk("midrst.async_eos", 32'(eos_en_o), 32'd0);
        @(negedge clk_i);
        cycle();
        chk("midrst.held_page", 32'(cart_page_o), 32'd1);
        reset_n_i = 1'b1;
        cycle();
        chk("midrst.rel_page", 32'(cart_page_o), 32'd3);
        chk("midrst.rel_bsw", 32'(bank_switch_o), 32'd1);
        cycle();
        chk("midrst.hold_bsw", 32'(bank_switch_o), 32'd0);
        check_model("midrst.model");

        // randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            logic [15:0] a;
            logic [4:0]  st;
            logic [1:0]  md;
            logic [PW-1:0] mk;
            md = mapper_mode_i;
            mk = cart_mask_i;
            if ($urandom_range(0, 19) == 0) md = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) mk = PW'($urandom);
            case ($urandom_range(0, 7))
                0: a = 16'h8000 | 16'($urandom_range(0, 16'h3FFF));
                1: a = 16'hC000 | 16'($urandom_range(0, 16'h3FFF));
                2: a = 16'hFFC0 | 16'($urandom_range(0, 63));
                3: a = 16'h0060;
                4: a = 16'h0061;
                5: a = 16'h007F;
                6: a = 16'h003F;
                default: a = 16'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0, 1: st = IDLE;
                2: st = MRD;
                3: st = MWR;
                4: st = IOWR;
                5: st = IORD;
                6: st = BOTH;
                default: st = RFSH;
            endcase
            drive(md, mk, a, 8'($urandom), st);
            if (!reset_n_i) begin
                reset_n_i = 1'b1;
            end else if ($urandom_range(0, 149) == 0) begin
                adam_i = 1'($urandom);
                reset_n_i = 1'b0;
                model_reset();
            end
            cycle();
            check_model($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
